// File: rtl/rtsnoc_int_tx.sv
// Interrupt-forwarding transmitter for one RTSNoC local port: sends UP/DOWN (level)
// or PULSE (rising-edge) one-flit packets to a fixed node and drains inbound flits.
module rtsnoc_int_tx #(
    parameter int NOC_DATA_WIDTH    = 32,
    parameter int NOC_LOCAL_ADR     = 0,
    parameter int NOC_X             = 0,
    parameter int NOC_Y             = 0,
    parameter int NOC_LOCAL_ADR_TGT = 0,
    parameter int NOC_X_TGT         = 0,
    parameter int NOC_Y_TGT         = 0,
    parameter int SOC_SIZE_X        = 1,
    parameter int SOC_SIZE_Y        = 1,
    parameter int PULSE_MODE        = 0,
    parameter int PEND_W            = 3,
    localparam int NOC_BUS_SIZE     = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    int_i,
    output logic [NOC_BUS_SIZE-1:0] noc_din_o,
    output logic                    noc_wr_o,
    output logic                    noc_rd_o,
    input  logic [NOC_BUS_SIZE-1:0] noc_dout_i,
    input  logic                    noc_wait_i,
    input  logic                    noc_nd_i
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam int HDR_W = NOC_BUS_SIZE - NOC_DATA_WIDTH;
    localparam logic [HDR_W-1:0] HDR = {SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), 3'(NOC_LOCAL_ADR),
                                        SOC_SIZE_X'(NOC_X_TGT), SOC_SIZE_Y'(NOC_Y_TGT),
                                        3'(NOC_LOCAL_ADR_TGT)};
    localparam logic [1:0] T_UP = 2'd1, T_DOWN = 2'd2, T_PULSE = 2'd3;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t                    state_q, state_d;
    logic                      s1_q, int_s_q, int_s_d_q;
    logic                      sent_q, sent_d;
    logic [PEND_W-1:0]         pend_q, pend_d;
    logic [7:0]                seq_q, seq_d;
    logic [NOC_DATA_WIDTH-1:0] data_q, data_d;
    logic                      wr_q, wr_d;
    logic                      rd_q;
    logic                      rise, dec;
    logic                      unused_dout;

    assign unused_dout = ^noc_dout_i;
    assign rise        = (PULSE_MODE != 0) && int_s_q && !int_s_d_q;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        data_d  = data_q;
        sent_d  = sent_q;
        seq_d   = seq_q;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (PULSE_MODE == 0) begin
                    if (int_s_q != sent_q) begin
                        data_d       = '0;
                        data_d[15:8] = seq_q;
                        data_d[1:0]  = int_s_q ? T_UP : T_DOWN;
                        sent_d       = int_s_q;
                        wr_d         = 1'b1;
                        state_d      = SEND;
                    end
                end else if (pend_q != '0) begin
                    data_d       = '0;
                    data_d[15:8] = seq_q;
                    data_d[1:0]  = T_PULSE;
                    dec          = 1'b1;
                    wr_d         = 1'b1;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (wr_q && !noc_wait_i) begin
                    wr_d    = 1'b0;
                    seq_d   = seq_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Simultaneous edge and launch cancel; edges beyond the counter range are lost.
        pend_d = pend_q;
        if (rise && !dec && pend_q != PEND_MAX)
            pend_d = pend_q + PEND_W'(1);
        else if (!rise && dec)
            pend_d = pend_q - PEND_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            int_s_q   <= 1'b0;
            int_s_d_q <= 1'b0;
            sent_q    <= 1'b0;
            pend_q    <= '0;
            seq_q     <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= int_i;
            int_s_q   <= s1_q;
            int_s_d_q <= int_s_q;
            sent_q    <= sent_d;
            pend_q    <= pend_d;
            seq_q     <= seq_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            rd_q      <= noc_nd_i & ~rd_q;
        end
    end

    assign noc_din_o = {HDR, data_q};
    assign noc_wr_o  = wr_q;
    assign noc_rd_o  = rd_q;
endmodule

// File: tb/tb_rtsnoc_int_tx.sv
// Bench for rtsnoc_int_tx: a level-mode and a pulse-mode instance share stimulus and are
// checked every cycle against a transaction-level reference, plus directed literal checks.
module tb_rtsnoc_int_tx;
    localparam int BW   = 46;
    localparam int PMAX = 7;
    localparam logic [13:0] HDR = {2'd1, 2'd2, 3'd3, 2'd2, 2'd1, 3'd5};

    logic          clk = 1'b0;
    logic          rst, int_l, wt, nd;
    logic [BW-1:0] dout;
    logic [1:0]    wr, rd;
    logic [BW-1:0] din [2];

    int n_cmp = 0;
    int n_err = 0;
    int acc  [2];
    int lseq [2];
    string tag [2];

    // reference state per instance
    bit        m_s1 [2], m_s [2], m_sd [2], m_sent [2], m_busy [2], m_rd [2];
    int        m_pend [2], m_seq [2];
    logic [15:0] m_data [2];

    always #5 clk = ~clk;

    rtsnoc_int_tx #(.NOC_DATA_WIDTH(32), .NOC_LOCAL_ADR(3), .NOC_X(1), .NOC_Y(2),
                    .NOC_LOCAL_ADR_TGT(5), .NOC_X_TGT(2), .NOC_Y_TGT(1),
                    .SOC_SIZE_X(2), .SOC_SIZE_Y(2), .PULSE_MODE(0), .PEND_W(3)) u_lvl (
        .clk_i(clk), .rst_i(rst), .int_i(int_l), .noc_din_o(din[0]), .noc_wr_o(wr[0]),
        .noc_rd_o(rd[0]), .noc_dout_i(dout), .noc_wait_i(wt), .noc_nd_i(nd));

    rtsnoc_int_tx #(.NOC_DATA_WIDTH(32), .NOC_LOCAL_ADR(3), .NOC_X(1), .NOC_Y(2),
                    .NOC_LOCAL_ADR_TGT(5), .NOC_X_TGT(2), .NOC_Y_TGT(1),
                    .SOC_SIZE_X(2), .SOC_SIZE_Y(2), .PULSE_MODE(1), .PEND_W(3)) u_pls (
        .clk_i(clk), .rst_i(rst), .int_i(int_l), .noc_din_o(din[1]), .noc_wr_o(wr[1]),
        .noc_rd_o(rd[1]), .noc_dout_i(dout), .noc_wait_i(wt), .noc_nd_i(nd));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Packet-level reference: the line is seen two samples late, a packet occupies the
    // port until accepted, level mode reports the current level if it differs from the
    // last one reported, pulse mode queues up to PMAX rising edges.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_s1[i] = 0; m_s[i] = 0; m_sd[i] = 0; m_sent[i] = 0; m_busy[i] = 0;
                m_rd[i] = 0; m_pend[i] = 0; m_seq[i] = 0; m_data[i] = '0;
            end else begin
                bit rise_e, launch;
                rise_e = (i == 1) && m_s[i] && !m_sd[i];
                launch = 0;
                if (m_busy[i]) begin
                    if (!wt) begin
                        m_busy[i] = 0;
                        m_seq[i]  = (m_seq[i] + 1) % 256;
                    end
                end else if (i == 0) begin
                    if (m_s[i] != m_sent[i]) begin
                        m_busy[i] = 1;
                        m_data[i] = {8'(m_seq[i]), m_s[i] ? 8'h01 : 8'h02};
                        m_sent[i] = m_s[i];
                    end
                end else if (m_pend[i] > 0) begin
                    m_busy[i] = 1;
                    m_data[i] = {8'(m_seq[i]), 8'h03};
                    launch    = 1;
                end
                if (rise_e && !launch)      m_pend[i] = (m_pend[i] < PMAX) ? m_pend[i] + 1 : PMAX;
                else if (launch && !rise_e) m_pend[i] = m_pend[i] - 1;
                m_rd[i] = nd && !m_rd[i];
                m_sd[i] = m_s[i];
                m_s[i]  = m_s1[i];
                m_s1[i] = int_l;
            end
        end
    endtask

    // One clock: log acceptances, advance the reference, compare on the falling edge.
    task automatic tick();
        for (int i = 0; i < 2; i++)
            if (!rst && wr[i] && !wt) begin
                acc[i]++;
                lseq[i] = int'(din[i][15:8]);
            end
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk({tag[i], ".wr"},  {63'b0, wr[i]}, {63'b0, m_busy[i]});
            chk({tag[i], ".din"}, 64'(din[i]), 64'({HDR, 16'h0, m_data[i]}));
            chk({tag[i], ".rd"},  {63'b0, rd[i]}, {63'b0, m_rd[i]});
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_wr(input int i, input int lim);
        int n;
        n = 0;
        while (!wr[i] && n < lim) begin
            tick();
            n++;
        end
        chk({tag[i], ".wr_timeout"}, {63'b0, wr[i]}, 64'd1);
    endtask

    initial begin
        int base, n;
        tag[0] = "lvl"; tag[1] = "pls";
        acc[0] = 0; acc[1] = 0; lseq[0] = 0; lseq[1] = 0;
        rst = 1; int_l = 0; wt = 0; nd = 0; dout = '0;
        @(negedge clk);
        ticks(3);
        chk("reset.wr",  {63'b0, wr[0]}, 64'd0);
        chk("reset.rd",  {63'b0, rd[0]}, 64'd0);
        chk("reset.din", 64'(din[0]), 64'({HDR, 32'h0}));
        rst = 0;
        tick();

        // first UP / DOWN with exact latency
        int_l = 1;
        tick(); chk("t1.lat0", {63'b0, wr[0]}, 64'd0);
        tick(); chk("t1.lat1", {63'b0, wr[0]}, 64'd0);
        tick(); chk("t1.up_wr", {63'b0, wr[0]}, 64'd1);
        chk("t1.up_din", 64'(din[0]), 64'({HDR, 32'h0000_0001}));
        tick(); chk("t1.up_1cyc", {63'b0, wr[0]}, 64'd0);
        chk("t1.pulse_wr", {63'b0, wr[1]}, 64'd1);
        chk("t1.pulse_din", 64'(din[1]), 64'({HDR, 32'h0000_0003}));
        ticks(2);
        int_l = 0;
        ticks(3);
        chk("t1.down_wr", {63'b0, wr[0]}, 64'd1);
        chk("t1.down_din", 64'(din[0]), 64'({HDR, 32'h0000_0102}));
        tick(); chk("t1.down_1cyc", {63'b0, wr[0]}, 64'd0);

        // back-pressure holds the flit
        wt = 1; int_l = 1;
        wait_wr(0, 10);
        for (int k = 0; k < 20; k++) begin
            chk("t2.hold_wr", {63'b0, wr[0]}, 64'd1);
            chk("t2.hold_din", 64'(din[0]), 64'({HDR, 32'h0000_0201}));
            tick();
        end
        base = acc[0];
        wt = 0;
        tick(); chk("t2.release_wr", {63'b0, wr[0]}, 64'd0);
        ticks(3);
        chk("t2.one_accept", 64'(acc[0] - base), 64'd1);

        // level coalescing during SEND
        int_l = 0; ticks(6);
        wt = 1; int_l = 1;
        wait_wr(0, 10);
        chk("t3.up_din", 64'(din[0]), 64'({HDR, 32'h0000_0401}));
        int_l = 0; ticks(3);
        int_l = 1; ticks(3);
        base = acc[0];
        wt = 0; ticks(10);
        chk("t3.one_packet", 64'(acc[0] - base), 64'd1);
        chk("t3.idle_after", {63'b0, wr[0]}, 64'd0);

        // pulse counting with saturation
        rst = 1; wt = 1; int_l = 0; ticks(2);
        rst = 0; tick();
        base = acc[1];
        for (int k = 0; k < 10; k++) begin
            int_l = 1; ticks(4);
            int_l = 0; ticks(4);
        end
        wt = 0; ticks(40);
        n = acc[1] - base;
        chk("t4.count_7_or_8", {63'b0, (n == 7 || n == 8)}, 64'd1);
        chk("t4.last_seq", 64'(lseq[1]), 64'(n - 1));

        // drain pulses while the line wiggles
        nd = 1;
        for (int k = 0; k < 6; k++) begin
            int_l = k[1];
            tick();
            chk("t5.rd", {63'b0, rd[0]}, {63'b0, (k % 2 == 0)});
        end
        nd = 0;

        // reset in the middle of SEND
        wt = 0; int_l = 0; ticks(8);
        wt = 1; int_l = 1;
        wait_wr(0, 10);
        rst = 1;
        tick(); chk("t6.rst_wr", {63'b0, wr[0]}, 64'd0);
        rst = 0; wt = 0;
        tick(); chk("t6.lat0", {63'b0, wr[0]}, 64'd0);
        tick(); chk("t6.lat1", {63'b0, wr[0]}, 64'd0);
        tick(); chk("t6.up_wr", {63'b0, wr[0]}, 64'd1);
        chk("t6.up_din", 64'(din[0]), 64'({HDR, 32'h0000_0001}));

        // sequence number wraps 255 -> 0
        rst = 1; int_l = 0; tick();
        rst = 0; tick();
        base = acc[0];
        for (int k = 0; k < 257; k++) begin
            int_l = ~int_l;
            ticks(6);
        end
        ticks(4);
        chk("wrap.count", 64'(acc[0] - base), 64'd257);
        chk("wrap.seq", 64'(lseq[0]), 64'd0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) int_l = ~int_l;
            wt   = ($urandom_range(0, 2) == 0);
            nd   = $urandom_range(0, 1) == 1;
            rst  = ($urandom_range(0, 399) == 0);
            dout = {$urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
